npu_dma_ctrl: RTL and testbench
===============================

NPU_DMA_CTRL -- requirements
Module: npu_dma_ctrl

Interface
REQ-001 SHALL have parameter MAX_BURST_BEATS, default 16, meaning max beats per AXI burst (power of two, 1..256).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports dma_req_valid input 1, dma_req_ready output 1, dma_req_src input 64, dma_req_dst input 64, dma_req_bytes input 32: copy request.
REQ-005 SHALL have ports dma_resp_done output 1, dma_resp_err output 1: one-cycle completion pulse; err qualifies done.
REQ-006 SHALL have AR ports m_axi_arvalid out 1, m_axi_arready in 1, m_axi_araddr out 64, m_axi_arlen out 8, m_axi_arsize out 3.
REQ-007 SHALL have R ports m_axi_rvalid in 1, m_axi_rready out 1, m_axi_rdata in 256, m_axi_rlast in 1.
REQ-008 SHALL have AW ports m_axi_awvalid out 1, m_axi_awready in 1, m_axi_awaddr out 64, m_axi_awlen out 8, m_axi_awsize out 3.
REQ-009 SHALL have W/B ports m_axi_wvalid out 1, m_axi_wready in 1, m_axi_wdata out 256, m_axi_wstrb out 32, m_axi_wlast out 1, m_axi_bvalid in 1, m_axi_bready out 1.

Function
REQ-010 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
REQ-011 SHALL assert dma_req_ready only in IDLE; request accepted on valid&&ready, src/dst/bytes latched that cycle.
REQ-012 SHALL, on accept with bytes==0, go to DONE (done pulse next cycle, err=0, no AXI traffic).
REQ-013 SHALL, on accept with src[4:0], dst[4:0] or bytes[4:0] nonzero, go to DONE with dma_resp_err=1 and no AXI traffic.
REQ-014 SHALL otherwise go to RD_ADDR; chunk beats = min(MAX_BURST_BEATS, remaining_bytes/32).
REQ-015 SHALL drive arlen/awlen = beats-1, arsize/awsize = 3'b101, wstrb = all ones.
REQ-016 SHALL hold arvalid with stable araddr until arready, then enter RD_DATA.
REQ-017 SHALL hold rready=1 in RD_DATA, store each rvalid beat into a MAX_BURST_BEATS x 256 buffer, leave after beats counted (rlast ignored).
REQ-018 SHALL hold awvalid until awready, then WR_DATA; wvalid=1 with buffer data, advance on wready, wlast on final beat.
REQ-019 SHALL hold bready=1 in WR_RESP; on bvalid advance src/dst by beats*32, decrement remaining; remaining==0 -> DONE else RD_ADDR.
REQ-020 SHALL pulse dma_resp_done exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL never have a read and a write burst outstanding simultaneously.

Reset
REQ-022 SHALL, on rst_n low at any time, enter IDLE asynchronously; all valid/ready/done/err outputs 0, addresses/len/counters 0, in-flight transfer abandoned, no done pulse.
REQ-023 SHALL assert dma_req_ready in the first cycle after rst_n deasserts.

Configuration
REQ-024 SHALL, with NPU_DMA_4K_SPLIT_EN defined, additionally cap chunk beats so neither src nor dst burst crosses a 4 KiB boundary (beats = min of REQ-014 value, (4096-src[11:0])/32, (4096-dst[11:0])/32).
REQ-025 SHALL, without NPU_DMA_4K_SPLIT_EN, use REQ-014 chunking only; 4 KiB crossings permitted.

Verification
REQ-026 SHALL test src=0x0, dst=0x100, bytes=32 -> one AR/AW len 0, dst bytes match src, one done pulse, err=0.
REQ-027 SHALL test src=0x0, dst=0x800, bytes=1024 -> two read then two write bursts len 15, addresses 0x0/0x200 and 0x800/0xA00.
REQ-028 SHALL test with macro, src=0xF00, dst=0x2000, bytes=512 -> bursts len 7 at 0xF00 then len 7 at 0x1000; without macro single len 15.
REQ-029 SHALL test bytes=0 -> done next cycle, err=0; src=0x4, bytes=32 -> done with err=1; both with no AXI valid asserted.
REQ-030 SHALL test wready toggling 1/0 and arready delayed 5 cycles on 64-byte copy -> data intact, wlast only on beat 2.
REQ-031 SHALL test rst_n low mid-RD_DATA -> all valids 0 immediately, no done, ready=1 after release, next 32-byte copy completes.

Source files
------------

// File: rtl/npu_dma_ctrl.sv
//-----------------------------------------------------------------------------
// npu_dma_ctrl
//
// Memory-to-memory copy engine for the NPU. A copy request (src, dst, bytes)
// is split into chunks. Each chunk is read into a local burst buffer with one
// AXI read burst, then written out with one AXI write burst. Only one burst
// (read or write) is in flight at any time. Each request ends with a
// one-cycle done pulse. The pulse carries err=1 for misaligned requests.
//
// Optional feature macro:
//   NPU_DMA_4K_SPLIT_EN - when defined, chunks are also capped so that neither
//                         the source nor the destination burst crosses a
//                         4 KiB boundary.
//
// Parameters:
//   MAX_BURST_BEATS  - maximum beats per AXI burst (power of two, 1..256)
//
// Ports:
//   clk, rst_n                        - clock, asynchronous active-low reset
//   dma_req_valid/ready/src/dst/bytes - copy request handshake and payload
//   dma_resp_done, dma_resp_err       - one-cycle completion pulse, err flag
//   m_axi_ar*                         - AXI read address channel
//   m_axi_r*                          - AXI read data channel
//   m_axi_aw*                         - AXI write address channel
//   m_axi_w*, m_axi_b*                - AXI write data and response channels
//-----------------------------------------------------------------------------
module npu_dma_ctrl #(
  parameter int unsigned MAX_BURST_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dma_req_valid,
  output logic         dma_req_ready,
  input  logic [63:0]  dma_req_src,
  input  logic [63:0]  dma_req_dst,
  input  logic [31:0]  dma_req_bytes,
  output logic         dma_resp_done,
  output logic         dma_resp_err,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  output logic [63:0]  m_axi_araddr,
  output logic [7:0]   m_axi_arlen,
  output logic [2:0]   m_axi_arsize,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready,
  input  logic [255:0] m_axi_rdata,
  input  logic         m_axi_rlast,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [63:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  output logic [255:0] m_axi_wdata,
  output logic [31:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready
);

  localparam int unsigned IDX_W        = (MAX_BURST_BEATS > 1) ? $clog2(MAX_BURST_BEATS) : 1;
  localparam logic [31:0] MAX_BEATS_C  = 32'(MAX_BURST_BEATS);
  localparam logic [2:0]  AXI_SIZE_32B = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5,
    DONE    = 3'd6
  } state_e;

  state_e         state_r, state_nxt_s;
  logic [63:0]    src_r, src_nxt_s;
  logic [63:0]    dst_r, dst_nxt_s;
  logic [31:0]    rem_r, rem_nxt_s;
  logic [7:0]     len_r, len_nxt_s;
  logic [8:0]     cnt_r, cnt_nxt_s;
  logic           err_nxt_s;
  logic           buf_we_s;
  logic           misalign_s;
  logic [8:0]     beats_s;
  logic [31:0]    step32_s;
  logic [63:0]    step64_s;
  logic [31:0]    rem_after_s;
  logic [63:0]    src_after_s;
  logic [63:0]    dst_after_s;

  logic           req_ready_r;
  logic           arvalid_r;
  logic           rready_r;
  logic           awvalid_r;
  logic           wvalid_r;
  logic           wlast_r;
  logic           bready_r;
  logic           done_r;
  logic           err_r;
  logic [255:0]   wdata_r;

  logic [255:0]   data_buf_r [MAX_BURST_BEATS];

  // Read bursts always return exactly arlen+1 beats here, so rlast carries
  // no extra information; beats are counted instead.
  logic           rlast_unused_s;
  assign rlast_unused_s = m_axi_rlast;

  // Burst length (beats-1) for the next chunk. rem is a nonzero multiple of
  // 32, so beats is at least one. The *_blk arguments are address bits
  // [11:5], i.e. the 32-byte slot inside the current 4 KiB page.
  function automatic logic [7:0] chunk_len(input logic [31:0] rem,
                                           input logic [6:0]  src_blk,
                                           input logic [6:0]  dst_blk);
    logic [31:0] beats;
    logic [31:0] lim;
    logic        unused_blk_s;
    unused_blk_s = ^{src_blk, dst_blk};
    lim          = 32'd0;
    beats        = {5'd0, rem[31:5]};
    if (beats > MAX_BEATS_C) begin
      beats = MAX_BEATS_C;
    end else begin
      beats = beats;
    end
`ifdef NPU_DMA_4K_SPLIT_EN
    // Beats left before the page end: (4096 - addr[11:0]) / 32.
    lim = 32'd128 - {25'd0, src_blk};
    if (beats > lim) begin
      beats = lim;
    end else begin
      beats = beats;
    end
    lim = 32'd128 - {25'd0, dst_blk};
    if (beats > lim) begin
      beats = lim;
    end else begin
      beats = beats;
    end
`else
    lim = lim;
`endif
    chunk_len = 8'(beats - 32'd1);
  endfunction

  assign misalign_s  = |{dma_req_src[4:0], dma_req_dst[4:0], dma_req_bytes[4:0]};
  assign beats_s     = {1'b0, len_r} + 9'd1;
  assign step32_s    = {18'd0, beats_s, 5'd0};
  assign step64_s    = {50'd0, beats_s, 5'd0};
  assign rem_after_s = rem_r - step32_s;
  assign src_after_s = src_r + step64_s;
  assign dst_after_s = dst_r + step64_s;

  // Next-state and datapath-next logic of the copy sequencer.
  always_comb begin
    state_nxt_s = state_r;
    src_nxt_s   = src_r;
    dst_nxt_s   = dst_r;
    rem_nxt_s   = rem_r;
    len_nxt_s   = len_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = 1'b0;
    buf_we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (dma_req_valid && req_ready_r) begin
          src_nxt_s = dma_req_src;
          dst_nxt_s = dma_req_dst;
          rem_nxt_s = dma_req_bytes;
          cnt_nxt_s = 9'd0;
          if (dma_req_bytes == 32'd0) begin
            state_nxt_s = DONE;
          end else if (misalign_s) begin
            state_nxt_s = DONE;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = RD_ADDR;
            len_nxt_s   = chunk_len(dma_req_bytes, dma_req_src[11:5], dma_req_dst[11:5]);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_ADDR: begin
        if (arvalid_r && m_axi_arready) begin
          state_nxt_s = RD_DATA;
        end else begin
          state_nxt_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (rready_r && m_axi_rvalid) begin
          buf_we_s = 1'b1;
          if (cnt_r == {1'b0, len_r}) begin
            state_nxt_s = WR_ADDR;
            cnt_nxt_s   = 9'd0;
          end else begin
            cnt_nxt_s   = cnt_r + 9'd1;
          end
        end else begin
          state_nxt_s = RD_DATA;
        end
      end
      WR_ADDR: begin
        if (awvalid_r && m_axi_awready) begin
          state_nxt_s = WR_DATA;
        end else begin
          state_nxt_s = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (wvalid_r && m_axi_wready) begin
          if (cnt_r == {1'b0, len_r}) begin
            state_nxt_s = WR_RESP;
            cnt_nxt_s   = 9'd0;
          end else begin
            cnt_nxt_s   = cnt_r + 9'd1;
          end
        end else begin
          state_nxt_s = WR_DATA;
        end
      end
      WR_RESP: begin
        if (bready_r && m_axi_bvalid) begin
          src_nxt_s = src_after_s;
          dst_nxt_s = dst_after_s;
          rem_nxt_s = rem_after_s;
          if (rem_after_s == 32'd0) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RD_ADDR;
            len_nxt_s   = chunk_len(rem_after_s, src_after_s[11:5], dst_after_s[11:5]);
          end
        end else begin
          state_nxt_s = WR_RESP;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state, transfer addresses, remaining bytes and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      src_r   <= 64'd0;
      dst_r   <= 64'd0;
      rem_r   <= 32'd0;
      len_r   <= 8'd0;
      cnt_r   <= 9'd0;
    end else begin
      state_r <= state_nxt_s;
      src_r   <= src_nxt_s;
      dst_r   <= dst_nxt_s;
      rem_r   <= rem_nxt_s;
      len_r   <= len_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Handshake outputs are registered from the next state, so each one is high
  // exactly while the sequencer sits in the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      wlast_r     <= 1'b0;
      bready_r    <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      wdata_r     <= 256'd0;
    end else begin
      req_ready_r <= (state_nxt_s == IDLE);
      arvalid_r   <= (state_nxt_s == RD_ADDR);
      rready_r    <= (state_nxt_s == RD_DATA);
      awvalid_r   <= (state_nxt_s == WR_ADDR);
      wvalid_r    <= (state_nxt_s == WR_DATA);
      wlast_r     <= (state_nxt_s == WR_DATA) && (cnt_nxt_s == {1'b0, len_nxt_s});
      bready_r    <= (state_nxt_s == WR_RESP);
      done_r      <= (state_nxt_s == DONE);
      err_r       <= err_nxt_s;
      if (state_nxt_s == WR_DATA) begin
        wdata_r <= data_buf_r[cnt_nxt_s[IDX_W-1:0]];
      end else begin
        wdata_r <= 256'd0;
      end
    end
  end

  // Burst buffer: pure storage, contents are only read after being written
  // in the same chunk, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      data_buf_r[cnt_r[IDX_W-1:0]] <= m_axi_rdata;
    end
  end

  assign dma_req_ready = req_ready_r;
  assign dma_resp_done = done_r;
  assign dma_resp_err  = err_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_araddr  = src_r;
  assign m_axi_arlen   = len_r;
  assign m_axi_arsize  = AXI_SIZE_32B;
  assign m_axi_rready  = rready_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_awaddr  = dst_r;
  assign m_axi_awlen   = len_r;
  assign m_axi_awsize  = AXI_SIZE_32B;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = 32'hFFFF_FFFF;
  assign m_axi_wlast   = wlast_r;
  assign m_axi_bready  = bready_r;

endmodule

// File: tb/tb_npu_dma_ctrl.sv
//-----------------------------------------------------------------------------
// tb_npu_dma_ctrl
//
// Directed bench for npu_dma_ctrl. A behavioural AXI slave with a small
// memory serves the bursts. Expected AR/AW/W/done responses are queued when
// a request is issued, and a monitor pops and compares them as the DUT
// presents each handshake.
//-----------------------------------------------------------------------------
module tb_npu_dma_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dma_req_valid;
  logic         dma_req_ready;
  logic [63:0]  dma_req_src;
  logic [63:0]  dma_req_dst;
  logic [31:0]  dma_req_bytes;
  logic         dma_resp_done;
  logic         dma_resp_err;
  logic         m_axi_arvalid, m_axi_arready;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic         m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [255:0] m_axi_rdata;
  logic         m_axi_awvalid, m_axi_awready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic         m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_bvalid, m_axi_bready;

  always #5 clk = ~clk;

  npu_dma_ctrl #(.MAX_BURST_BEATS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst), .dma_req_bytes(dma_req_bytes),
    .dma_resp_done(dma_resp_done), .dma_resp_err(dma_resp_err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } addr_t;
  typedef struct packed { logic [255:0] data; logic last; } wbeat_t;
  addr_t  ar_q[$];
  addr_t  aw_q[$];
  wbeat_t w_q[$];
  logic   done_q[$];

  logic [255:0] mem [0:1023];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [63:0] a);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = (a[31:0] + 32'(k)) ^ 32'hC0DE_0000;
    return v;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = pat(64'(i) << 5);
  endtask

  // One read burst then one write burst of len+1 beats.
  task automatic push_burst(input logic [63:0] s, input logic [63:0] d, input logic [7:0] l);
    ar_q.push_back('{addr: s, len: l});
    aw_q.push_back('{addr: d, len: l});
    for (int i = 0; i <= int'(l); i++)
      w_q.push_back('{data: pat(s + 64'(i) * 64'd32), last: (i == int'(l))});
  endtask

  task automatic chk_copy(input string name, input logic [63:0] s, input logic [63:0] d, input int beats);
    logic [63:0] a;
    for (int i = 0; i < beats; i++) begin
      a = d + 64'(i) * 64'd32;
      chk(name, mem[a[14:5]], pat(s + 64'(i) * 64'd32));
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [63:0] s, input logic [63:0] d, input logic [31:0] b);
    int t;
    t = 0;
    while (!dma_req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", dma_req_ready, 1'b1);
    dma_req_src   = s;
    dma_req_dst   = d;
    dma_req_bytes = b;
    dma_req_valid = 1'b1;
    @(negedge clk);
    dma_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (done_cnt < exp_done && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("done_within_budget", done_cnt, exp_done);
  endtask

  task automatic chk_queues_empty();
    chk("ar_q_empty", ar_q.size(), 0);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
  endtask

  // ---------------- AXI slave model ----------------
  int          ar_delay = 0;
  int          ar_wait;
  bit          wtog = 1'b0;
  bit          wphase;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, b_pend;
  logic [63:0] ar_addr_l, aw_addr_l, rd_addr, wr_addr;
  logic [7:0]  ar_len_l;
  int          rd_left;
  logic [255:0] w_data_l;
  logic        w_last_l;

  task automatic slave_clear();
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; b_pend = 0;
    ar_wait = 0; rd_left = 0; wphase = 0;
    rd_addr = 0; wr_addr = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slave_clear();
      end else begin
        // Retire handshakes that completed on the preceding rising edge.
        if (ar_hs) begin rd_addr = ar_addr_l; rd_left = int'(ar_len_l) + 1; end
        if (r_hs)  begin rd_addr = rd_addr + 64'd32; rd_left--; end
        if (aw_hs) wr_addr = aw_addr_l;
        if (w_hs) begin
          mem[wr_addr[14:5]] = w_data_l;
          wr_addr = wr_addr + 64'd32;
          if (w_last_l) b_pend = 1;
        end
        if (b_hs) b_pend = 0;
        if (m_axi_arvalid) begin
          m_axi_arready = (ar_wait >= ar_delay);
          ar_wait++;
        end else begin
          m_axi_arready = 0;
          ar_wait = 0;
        end
        ar_hs = m_axi_arvalid && m_axi_arready;
        ar_addr_l = m_axi_araddr;
        ar_len_l = m_axi_arlen;
        m_axi_rvalid = (rd_left > 0);
        m_axi_rdata = mem[rd_addr[14:5]];
        m_axi_rlast = (rd_left == 1);
        r_hs = m_axi_rvalid && m_axi_rready;
        m_axi_awready = m_axi_awvalid;
        aw_hs = m_axi_awvalid && m_axi_awready;
        aw_addr_l = m_axi_awaddr;
        wphase = ~wphase;
        m_axi_wready = wtog ? wphase : 1'b1;
        w_hs = m_axi_wvalid && m_axi_wready;
        w_data_l = m_axi_wdata;
        w_last_l = m_axi_wlast;
        m_axi_bvalid = b_pend;
        b_hs = m_axi_bvalid && m_axi_bready;
      end
    end
  end

  // ---------------- Scoreboard monitor ----------------
  initial begin
    addr_t       ea;
    wbeat_t      ew;
    logic        prev_ar_pend;
    logic [63:0] prev_araddr;
    prev_ar_pend = 0;
    prev_araddr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (prev_ar_pend) chk("ar_held_stable", {m_axi_arvalid, m_axi_araddr}, {1'b1, prev_araddr});
      prev_ar_pend = m_axi_arvalid && !m_axi_arready;
      prev_araddr = m_axi_araddr;
      if (m_axi_arvalid) begin
        chk("ar_expected", ar_q.size() != 0, 1'b1);
        if (m_axi_arready && ar_q.size() != 0) begin
          ea = ar_q.pop_front();
          chk("araddr", m_axi_araddr, ea.addr);
          chk("arlen", m_axi_arlen, ea.len);
          chk("arsize", m_axi_arsize, 3'b101);
        end
      end
      if (m_axi_awvalid) begin
        chk("aw_expected", aw_q.size() != 0, 1'b1);
        if (m_axi_awready && aw_q.size() != 0) begin
          ea = aw_q.pop_front();
          chk("awaddr", m_axi_awaddr, ea.addr);
          chk("awlen", m_axi_awlen, ea.len);
          chk("awsize", m_axi_awsize, 3'b101);
        end
      end
      if (m_axi_wvalid) begin
        chk("w_expected", w_q.size() != 0, 1'b1);
        if (m_axi_wready && w_q.size() != 0) begin
          ew = w_q.pop_front();
          chk("wdata", m_axi_wdata, ew.data);
          chk("wlast", m_axi_wlast, ew.last);
          chk("wstrb", m_axi_wstrb, 32'hFFFF_FFFF);
        end
      end
      if (dma_resp_done) begin
        done_cnt++;
        chk("done_expected", done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) chk("done_err", dma_resp_err, done_q.pop_front());
      end else begin
        chk("err_only_with_done", dma_resp_err, 1'b0);
      end
      chk("no_rd_wr_overlap", (m_axi_arvalid | m_axi_rready) & (m_axi_awvalid | m_axi_wvalid | m_axi_bready), 1'b0);
    end
  end

  // ---------------- Directed tests ----------------
  initial begin
    int base_done;
    rst_n = 1'b0;
    dma_req_valid = 1'b0;
    dma_req_src = '0;
    dma_req_dst = '0;
    dma_req_bytes = '0;
    fill_mem();

    @(negedge clk);
    #1;
    chk("rst_req_ready", dma_req_ready, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_done", dma_resp_done, 1'b0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_arlen", m_axi_arlen, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_reset", dma_req_ready, 1'b1);
    @(negedge clk);

    // Single-beat copy.
    fill_mem();
    push_burst(64'h0, 64'h100, 8'd0);
    done_q.push_back(1'b0); exp_done++;
    issue(64'h0, 64'h100, 32'd32);
    wait_done(300);
    chk_copy("copy32_data", 64'h0, 64'h100, 1);
    chk_queues_empty();

    // 1 KiB copy: two 16-beat chunks.
    fill_mem();
    push_burst(64'h0, 64'h800, 8'd15);
    push_burst(64'h200, 64'hA00, 8'd15);
    done_q.push_back(1'b0); exp_done++;
    issue(64'h0, 64'h800, 32'd1024);
    wait_done(1000);
    chk_copy("copy1k_data", 64'h0, 64'h800, 32);
    chk_queues_empty();

    // Source crosses a 4 KiB page.
    fill_mem();
`ifdef NPU_DMA_4K_SPLIT_EN
    push_burst(64'hF00, 64'h2000, 8'd7);
    push_burst(64'h1000, 64'h2100, 8'd7);
`else
    push_burst(64'hF00, 64'h2000, 8'd15);
`endif
    done_q.push_back(1'b0); exp_done++;
    issue(64'hF00, 64'h2000, 32'd512);
    wait_done(1000);
    chk_copy("copy4k_data", 64'hF00, 64'h2000, 16);
    chk_queues_empty();

    // Zero-length request: done the cycle after accept, no error.
    done_q.push_back(1'b0); exp_done++;
    issue(64'h0, 64'h0, 32'd0);
    #1;
    chk("zero_done_next", dma_resp_done, 1'b1);
    chk("zero_err", dma_resp_err, 1'b0);
    wait_done(50);

    // Misaligned source: done with error.
    done_q.push_back(1'b1); exp_done++;
    issue(64'h4, 64'h100, 32'd32);
    #1;
    chk("misalign_done_next", dma_resp_done, 1'b1);
    chk("misalign_err", dma_resp_err, 1'b1);
    wait_done(50);
    chk_queues_empty();

    // Slow AR and toggling wready on a two-beat copy.
    fill_mem();
    ar_delay = 5;
    wtog = 1'b1;
    push_burst(64'h400, 64'hC00, 8'd1);
    done_q.push_back(1'b0); exp_done++;
    issue(64'h400, 64'hC00, 32'd64);
    wait_done(300);
    chk_copy("copy64_data", 64'h400, 64'hC00, 2);
    chk_queues_empty();
    ar_delay = 0;
    wtog = 1'b0;

    // Reset in the middle of a read burst.
    fill_mem();
    ar_q.push_back('{addr: 64'h0, len: 8'd15});
    base_done = done_cnt;
    issue(64'h0, 64'h1000, 32'd512);
    for (int t = 0; t < 50 && !m_axi_rready; t++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("in_rd_data", m_axi_rready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_mid_rready", m_axi_rready, 1'b0);
    chk("rst_mid_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_mid_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_mid_bready", m_axi_bready, 1'b0);
    chk("rst_mid_done", dma_resp_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_mid_reset", dma_req_ready, 1'b1);
    chk("no_done_from_abort", done_cnt, base_done);
    @(negedge clk);
    fill_mem();
    push_burst(64'h40, 64'h1800, 8'd0);
    done_q.push_back(1'b0); exp_done++;
    issue(64'h40, 64'h1800, 32'd32);
    wait_done(300);
    chk_copy("post_reset_data", 64'h40, 64'h1800, 1);
    chk_queues_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
